// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit, one bit per clock; divide datapath built only when MDU_DIV_EN is defined
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_err
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic sx, sy, to_fix, fix_err;
  logic [WIDTH-1:0] a, mx, my, fix_hi, fix_lo;
  logic [WIDTH:0] msum;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  assign op_ready = state == IDLE;
  assign res_valid = state == DONE;
  always_comb begin
    mx = (!op_code[0] && op_x[WIDTH-1]) ? -op_x : op_x;
    my = (!op_code[0] && op_y[WIDTH-1]) ? -op_y : op_y;
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & a};
    prod = (!op[0] && (sx ^ sy)) ? -acc : acc;
  end
`ifdef MDU_DIV_EN
  logic dz;
  logic [WIDTH:0] rem;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] rv, rs;
  always_comb begin
    diff = {rem, acc[WIDTH-1]} - {2'b0, a};
    rv = dz ? acc[WIDTH-1:0] : rem[WIDTH-1:0];
    rs = (!op[0] && sx) ? -rv : rv;
    to_fix = op_code[1] && op_y == '0;
    acc_nx = op[1] ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH+1]} : {msum, acc[WIDTH-1:1]};
    fix_hi = op[1] ? rs : prod[2*WIDTH-1:WIDTH];
    fix_lo = (op[1] && dz) ? '1 : prod[WIDTH-1:0];
    fix_err = op[1] && dz;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      dz <= 1'b0;
    end else if (state == IDLE) begin
      rem <= '0;
      dz <= to_fix;
    end else if (state == CALC && op[1])
      rem <= diff[WIDTH+1] ? {rem[WIDTH-1:0], acc[WIDTH-1]} : diff[WIDTH:0];
  end
`else
  always_comb begin
    to_fix = op_code[1];
    acc_nx = {msum, acc[WIDTH-1:1]};
    fix_hi = op[1] ? '0 : prod[2*WIDTH-1:WIDTH];
    fix_lo = op[1] ? '0 : prod[WIDTH-1:0];
    fix_err = op[1];
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
      a <= '0;
      acc <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_err <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          op <= op_code;
          sx <= !op_code[0] && op_x[WIDTH-1];
          sy <= !op_code[0] && op_y[WIDTH-1];
          a <= op_code[1] ? my : mx;
          acc <= {{WIDTH{1'b0}}, op_code[1] ? mx : my};
          state <= to_fix ? FIX : CALC;
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt == CW'(WIDTH - 1) ? '0 : cnt + CW'(1);
          state <= cnt == CW'(WIDTH - 1) ? FIX : CALC;
        end
        FIX: begin
          res_hi <= fix_hi;
          res_lo <= fix_lo;
          res_err <= fix_err;
          state <= DONE;
        end
        DONE: state <= res_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random checks of mdu_iter against a plain-arithmetic reference model
module tb_mdu_iter;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b1, op_valid = 1'b0, flush = 1'b0, res_ready = 1'b1;
  logic [1:0] op_code = '0;
  logic [W-1:0] op_x = '0, op_y = '0;
  logic op_ready, res_valid, res_err;
  logic [W-1:0] res_hi, res_lo;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_x(op_x), .op_y(op_y), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err)
  );
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx = longint'($signed(x)), sy = longint'($signed(y));
    longint ux = longint'({32'b0, x}), uy = longint'({32'b0, y});
    longint p, q, r;
    if (op[1]) begin
`ifdef MDU_DIV_EN
      if (y == '0) return {1'b1, x, {W{1'b1}}};
      q = op[0] ? ux / uy : sx / sy;
      r = op[0] ? ux % uy : sx % sy;
      return {1'b0, r[W-1:0], q[W-1:0]};
`else
      return {1'b1, 64'd0};
`endif
    end
    p = op[0] ? ux * uy : sx * sy;
    return {1'b0, p};
  endfunction
  function automatic int lat(input logic [1:0] op, input logic [W-1:0] y);
`ifdef MDU_DIV_EN
    return (op[1] && y == '0) ? 2 : W + 2;
`else
    return op[1] ? 2 : W + 2;
`endif
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int hold, input string tag);
    logic [64:0] e;
    int n;
    e = model(op, x, y);
    op_valid = 1'b1;
    op_code = op;
    op_x = x;
    op_y = y;
    chk({tag, "/ready"}, 72'(op_ready), 72'(1));
    tick;
    op_valid = 1'b0;
    op_x = $urandom;
    op_y = $urandom;
    res_ready = hold == 0;
    n = 1;
    while (!res_valid && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "/latency"}, 72'(n), 72'(lat(op, y)));
    chk({tag, "/result"}, 72'({res_err, res_hi, res_lo}), 72'(e));
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1;
      op_code = 2'($urandom_range(0, 3));
      op_x = $urandom;
      op_y = $urandom;
      tick;
      chk({tag, "/hold"}, 72'({res_valid, op_ready, res_err, res_hi, res_lo}), 72'({2'b10, e}));
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    tick;
    chk({tag, "/take"}, 72'({res_valid, op_ready}), 72'(2'b01));
    chk({tag, "/kept"}, 72'({res_err, res_hi, res_lo}), 72'(e));
  endtask
  initial begin
    int n;
    logic [W-1:0] x, y;
    logic [1:0] op;
    #2 rst_n = 1'b0;
    #1 chk("reset", 72'({op_ready, res_valid, res_err, res_hi, res_lo}), {5'd0, 3'b100, 64'd0});
    #9 rst_n = 1'b1;
    tick;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    run_op(2'b00, -32'sd3, 32'd5, 0, "mult_neg");
    run_op(2'b10, -32'sd7, 32'd2, 0, "div_neg");
    run_op(2'b11, 32'h1234, 32'd0, 0, "divu_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5, "div_wrap_hold");
    op_valid = 1'b1;
    op_code = 2'b01;
    op_x = $urandom;
    op_y = $urandom;
    tick;
    op_valid = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    op_valid = 1'b1;
    op_x = 32'd5;
    op_y = 32'd5;
    tick;
    flush = 1'b0;
    op_valid = 1'b0;
    chk("flush_idle", 72'({op_ready, res_valid}), 72'(2'b10));
    n = 0;
    repeat (W + 5) begin
      tick;
      if (res_valid || !op_ready) n++;
    end
    chk("flush_quiet", 72'(n), 72'(0));
    run_op(2'b01, 32'd7, 32'd6, 0, "multu_7x6");
    op_valid = 1'b1;
    op_code = 2'b00;
    op_x = $urandom;
    op_y = $urandom;
    tick;
    op_valid = 1'b0;
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1 chk("reset_mid", 72'({op_ready, res_valid, res_err, res_hi, res_lo}), {5'd0, 3'b100, 64'd0});
    @(negedge clk) rst_n = 1'b1;
    tick;
    run_op(2'b10, 32'd10, 32'd2, 0, "div_10_2");
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 4 == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i % 5 == 0) y = '0;
      if (i % 7 == 3) begin
        x = 32'h8000_0000;
        y = '1;
      end
      run_op(op, x, y, (i % 3 == 0) ? 2 : 0, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the MIPS datapath, the multi-cycle companion to the single-cycle ALU. It executes MULT/MULTU/DIV/DIVU one bit per clock and returns a HI/LO result pair through valid/ready handshakes. It sits beside the ALU in the execute stage; the pipeline stalls on `op_ready`/`res_valid`.

## Interface
- `WIDTH`, 32, operand width; even, ≥ 8.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  request valid.
- `op_ready`  out  1  unit idle and able to accept a request.
- `op_code`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `op_x`  in  WIDTH  multiplicand or dividend.
- `op_y`  in  WIDTH  multiplier or divisor.
- `flush`  in  1  synchronous cancel of any in-flight operation.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_hi`  out  WIDTH  product high half, or remainder.
- `res_lo`  out  WIDTH  product low half, or quotient.
- `res_err`  out  1  divide by zero, or unsupported operation.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - `op_ready` = (state == IDLE).
  - `res_valid` = (state == DONE).
- **Accept:** `op_valid & op_ready & !flush`. On accept, latch the operand magnitudes, the result signs and the op. Signed ops (MULT, DIV) use two's-complement magnitudes; unsigned ops use raw values.
- **IDLE → CALC** on accept.
  - Exception: divide with `op_y == 0` goes IDLE → FIX directly.
- **CALC:** one iteration per cycle for exactly WIDTH cycles, counted by a `$clog2(WIDTH)+1`-bit counter. Then → FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division; the remainder register is WIDTH+1 bits.
- **FIX:** apply sign correction and register the outputs, then → DONE.
  - MULT: negate the 2·WIDTH product if sign(x) ^ sign(y).
  - DIV: quotient sign = sign(x) ^ sign(y); remainder takes the sign of x.
- **DONE → IDLE** when `res_ready` is high.
- **Boundary results:**
  - Divide by zero: `res_lo` = all ones, `res_hi` = `op_x`, `res_err` = 1.
  - Signed DIV of −2^(W−1) by −1: `res_lo` = 0x80…0, `res_hi` = 0, `res_err` = 0 (wraps, no trap).
- **flush:** from any state, the next edge goes to IDLE, any pending result is discarded, and `res_valid` drops. `flush` has priority over a same-cycle `op_valid`.
- **Output hold:** outputs hold their values while `res_valid & !res_ready`, and keep their last values after the result is taken.

## Timing
- **Reset:** asserting `rst_n` low forces, immediately and regardless of state:
  - state = IDLE, so `op_ready` = 1;
  - `res_valid` = 0; `res_hi` = `res_lo` = 0; `res_err` = 0;
  - the iteration counter = 0.
  - Reset mid-operation abandons the operation with no output.
- **Latency** (counted from the accepting edge E0):
  - Normal op: `res_valid` goes high after edge E(WIDTH+2), i.e. 34 edges for WIDTH = 32.
  - Divide by zero: `res_valid` goes high after edge E2.
- **Throughput:** one operation per WIDTH+3 cycles when `res_ready` is held high. The next accept is possible in the cycle after the DONE→IDLE edge.
- Operands are sampled only at the accept edge. Changes on `op_x`/`op_y` afterwards have no effect.

## Configuration
- `MDU_DIV_EN` defined: full divide datapath is built, as described above.
- `MDU_DIV_EN` undefined:
  - The divide datapath and the WIDTH+1 remainder register are not synthesised.
  - DIV/DIVU are still accepted and go IDLE → FIX → DONE, with `res_valid` after edge E2.
  - Result is `res_hi` = `res_lo` = 0 and `res_err` = 1.
  - Multiply behaviour and latency are unchanged.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → `res_valid` after edge 34; `res_hi` = 0xFFFFFFFE, `res_lo` = 0x00000001, `res_err` = 0.
- MULT −3 × 5 → `res_hi` = 0xFFFFFFFF, `res_lo` = 0xFFFFFFF1. Then DIV −7 / 2 → `res_lo` = 0xFFFFFFFD, `res_hi` = 0xFFFFFFFF.
- DIVU 0x1234 / 0 → `res_valid` after edge 2; `res_lo` = 0xFFFFFFFF, `res_hi` = 0x00001234, `res_err` = 1. Then DIV 0x80000000 / 0xFFFFFFFF → `res_lo` = 0x80000000, `res_hi` = 0.
- Backpressure: hold `res_ready` low for 5 cycles after `res_valid`. Required: outputs stable, `op_ready` = 0, and `op_valid` ignored during the hold. Raising `res_ready` → IDLE on the next edge.
- Flush at CALC cycle 10 together with `op_valid` high → IDLE next edge, no `res_valid`, request not accepted. A following MULTU 7 × 6 → `res_lo` = 42.
- Drop `rst_n` low mid-CALC → all outputs reset immediately. Build without `MDU_DIV_EN`: DIV 10 / 2 → `res_err` = 1, `res_hi` = `res_lo` = 0 after edge 2.
